// File: rtl/perceptron_engine.sv
// APB-programmed perceptron: streams LEN pixel/weight words, multiply-accumulates every lane,
// adds a bias and reports a saturated score, a binary decision and a completion pulse.
module perceptron_engine #(
  parameter int AMBA_WORD       = 24,
  parameter int AMBA_ADDR_DEPTH = 12,
  parameter int CHANNELS        = 3,
  parameter int WEIGHT_W        = 5,
  parameter int ACC_W           = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         PSEL,
  input  logic                         PENABLE,
  input  logic                         PWRITE,
  input  logic [AMBA_ADDR_DEPTH-1:0]   PADDR,
  input  logic [AMBA_WORD-1:0]         PWDATA,
  output logic [AMBA_WORD-1:0]         PRDATA,
  output logic                         PREADY,
  output logic                         mem_rd_en,
  output logic [AMBA_ADDR_DEPTH-1:0]   mem_rd_addr,
  input  logic [AMBA_WORD-1:0]         pix_rd_data,
  input  logic [CHANNELS*WEIGHT_W-1:0] wgt_rd_data,
  output logic                         cat_rec_out,
  output logic [AMBA_WORD-1:0]         score,
  output logic                         done_irq
);

  localparam int PIXEL_W = AMBA_WORD / CHANNELS;
  localparam int AD      = AMBA_ADDR_DEPTH;

  localparam logic [AD-1:0] A_CTRL   = AD'(3'd0);
  localparam logic [AD-1:0] A_LEN    = AD'(3'd1);
  localparam logic [AD-1:0] A_BIAS   = AD'(3'd2);
  localparam logic [AD-1:0] A_STATUS = AD'(3'd3);
  localparam logic [AD-1:0] A_SCORE  = AD'(3'd4);

  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-AMBA_WORD+1){1'b0}}, {(AMBA_WORD-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W-AMBA_WORD+1){1'b1}}, {(AMBA_WORD-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_DRAIN = 3'd2,
    S_BIAS  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                    state_r, state_next_s;
  logic [AD-1:0]             idx_r, idx_next_s;
  logic                      rd_en_r, rd_en_next_s;
  logic                      rd_valid_r;
  logic signed [ACC_W-1:0]   acc_r;
  logic signed [ACC_W-1:0]   lane_sum_s;
  logic [AD-1:0]             len_r;
  logic [AMBA_WORD-1:0]      bias_r;
  logic                      done_r, cat_r, done_irq_r;
  logic [AMBA_WORD-1:0]      score_r;
  logic [AMBA_WORD-1:0]      prdata_s;
  logic                      wr_s, ctrl_wr_s, busy_s, go_s, kill_s;

  // Sum over all lanes of zero-extended pixel times sign-extended weight.
  function automatic logic signed [ACC_W-1:0] mac_word(
    input logic [AMBA_WORD-1:0]         pix,
    input logic [CHANNELS*WEIGHT_W-1:0] wgt
  );
    logic signed [ACC_W-1:0] px, wt, sum;
    sum = {ACC_W{1'b0}};
    for (int c = 0; c < CHANNELS; c++) begin
      px  = {{(ACC_W-PIXEL_W){1'b0}}, pix[c*PIXEL_W +: PIXEL_W]};
      wt  = {{(ACC_W-WEIGHT_W){wgt[c*WEIGHT_W+WEIGHT_W-1]}}, wgt[c*WEIGHT_W +: WEIGHT_W]};
      sum = sum + px * wt;
    end
    return sum;
  endfunction

  // Clamp the accumulator into the signed AMBA_WORD range.
  function automatic logic [AMBA_WORD-1:0] saturate(input logic signed [ACC_W-1:0] a);
    logic [AMBA_WORD-1:0] r;
    if (a > SAT_MAX) begin
      r = SAT_MAX[AMBA_WORD-1:0];
    end else if (a < SAT_MIN) begin
      r = SAT_MIN[AMBA_WORD-1:0];
    end else begin
      r = a[AMBA_WORD-1:0];
    end
    return r;
  endfunction

  assign wr_s      = PSEL & PENABLE & PWRITE;
  assign ctrl_wr_s = wr_s & (PADDR == A_CTRL);
  assign busy_s    = (state_r != S_IDLE);
  // Abort outranks start in the same write, so a combined write never launches a run.
  assign go_s      = ctrl_wr_s & PWDATA[0] & ~PWDATA[1] & ~busy_s;
  assign kill_s    = ctrl_wr_s & PWDATA[1] & busy_s;
  assign lane_sum_s = mac_word(pix_rd_data, wgt_rd_data);

  // Next-state, read index and read strobe for the sequencing FSM.
  always_comb begin
    state_next_s = state_r;
    idx_next_s   = idx_r;
    rd_en_next_s = 1'b0;
    if (kill_s) begin
      state_next_s = S_IDLE;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (go_s) begin
            idx_next_s = {AD{1'b0}};
            if (len_r != {AD{1'b0}}) begin
              state_next_s = S_RUN;
              rd_en_next_s = 1'b1;
            end else begin
              state_next_s = S_DRAIN;
            end
          end else begin
            state_next_s = S_IDLE;
          end
        end
        S_RUN: begin
          if (idx_r == len_r - AD'(1'b1)) begin
            state_next_s = S_DRAIN;
          end else begin
            idx_next_s   = idx_r + AD'(1'b1);
            rd_en_next_s = 1'b1;
          end
        end
        S_DRAIN: state_next_s = S_BIAS;
        S_BIAS:  state_next_s = S_DONE;
        S_DONE:  state_next_s = S_IDLE;
        default: state_next_s = S_IDLE;
      endcase
    end
  end

  // FSM state, read address/strobe and the one-cycle read-data valid delay.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= S_IDLE;
      idx_r      <= {AD{1'b0}};
      rd_en_r    <= 1'b0;
      rd_valid_r <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      idx_r      <= idx_next_s;
      rd_en_r    <= rd_en_next_s;
      rd_valid_r <= rd_en_r;
    end
  end

  // Programmable registers, accumulator and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_r      <= {AD{1'b0}};
      bias_r     <= {AMBA_WORD{1'b0}};
      acc_r      <= {ACC_W{1'b0}};
      done_r     <= 1'b0;
      cat_r      <= 1'b0;
      score_r    <= {AMBA_WORD{1'b0}};
      done_irq_r <= 1'b0;
    end else begin
      if (wr_s && !busy_s && PADDR == A_LEN) begin
        len_r <= PWDATA[AD-1:0];
      end
      if (wr_s && !busy_s && PADDR == A_BIAS) begin
        bias_r <= PWDATA;
      end
      // A read still in flight after an abort must not leak into the cleared accumulator.
      if (go_s || kill_s) begin
        acc_r <= {ACC_W{1'b0}};
      end else if (state_r == S_BIAS) begin
        acc_r <= acc_r + {{(ACC_W-AMBA_WORD){bias_r[AMBA_WORD-1]}}, bias_r};
      end else if (rd_valid_r && busy_s) begin
        acc_r <= acc_r + lane_sum_s;
      end
      if (state_r == S_DONE && !kill_s) begin
        score_r    <= saturate(acc_r);
        cat_r      <= ~acc_r[ACC_W-1] & (acc_r != {ACC_W{1'b0}});
        done_r     <= 1'b1;
        done_irq_r <= 1'b1;
      end else begin
        done_irq_r <= 1'b0;
        if (go_s) begin
          done_r <= 1'b0;
        end
      end
    end
  end

  // APB read mux; unmapped and write-only addresses read as zero.
  always_comb begin
    prdata_s = {AMBA_WORD{1'b0}};
    if (PSEL && !PWRITE) begin
      case (PADDR)
        A_LEN:    prdata_s = AMBA_WORD'(len_r);
        A_BIAS:   prdata_s = bias_r;
        A_STATUS: prdata_s = AMBA_WORD'({cat_r, done_r, busy_s});
        A_SCORE:  prdata_s = score_r;
        default:  prdata_s = {AMBA_WORD{1'b0}};
      endcase
    end else begin
      prdata_s = {AMBA_WORD{1'b0}};
    end
  end

  assign PRDATA      = prdata_s;
  assign PREADY      = 1'b1;
  assign mem_rd_en   = rd_en_r;
  assign mem_rd_addr = idx_r;
  assign cat_rec_out = cat_r;
  assign score       = score_r;
  assign done_irq    = done_irq_r;

endmodule

// File: tb/tb_perceptron_engine.sv
// Directed bench for perceptron_engine: memory models, a run scoreboard fed by a
// reference model, and checks on latency, results, status and abort/reset behaviour.
module tb_perceptron_engine;
  localparam int AW = 24, AD = 12, CH = 3, WW = 5, PW = 8;

  logic clk = 1'b0;
  logic rst;
  logic PSEL, PENABLE, PWRITE;
  logic [AD-1:0] PADDR;
  logic [AW-1:0] PWDATA, PRDATA;
  logic PREADY, mem_rd_en, cat_rec_out, done_irq;
  logic [AD-1:0] mem_rd_addr;
  logic [AW-1:0] pix_rd_data = '0;
  logic [CH*WW-1:0] wgt_rd_data = '0;
  logic [AW-1:0] score;

  logic [AW-1:0]    pmem [0:4095];
  logic [CH*WW-1:0] wmem [0:4095];

  typedef struct {
    logic [AW-1:0] score;
    logic          cat;
    int            len;
  } exp_t;
  exp_t sb[$];

  int tests = 0, fails = 0;
  int cyc = 0, irq_count = 0, rd_count = 0, addr_bad = 0;
  int start_cyc = 0;
  logic prev_en = 1'b0;
  logic [AD-1:0] prev_addr = '0;

  perceptron_engine dut (
    .clk(clk), .rst(rst), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
    .pix_rd_data(pix_rd_data), .wgt_rd_data(wgt_rd_data),
    .cat_rec_out(cat_rec_out), .score(score), .done_irq(done_irq)
  );

  always #5 clk = ~clk;

  // Synchronous-read pixel and weight memories.
  always @(posedge clk) begin
    if (mem_rd_en) begin
      pix_rd_data <= pmem[mem_rd_addr];
      wgt_rd_data <= wmem[mem_rd_addr];
    end
  end

  // Cycle counter, interrupt counter and read-address walk monitor.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (done_irq) irq_count <= irq_count + 1;
    if (mem_rd_en) begin
      rd_count <= rd_count + 1;
      if (prev_en ? (int'(mem_rd_addr) != int'(prev_addr) + 1) : (mem_rd_addr != '0))
        addr_bad <= addr_bad + 1;
    end
    prev_en   <= mem_rd_en;
    prev_addr <= mem_rd_addr;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic apb_write(input logic [AD-1:0] a, input logic [AW-1:0] d);
    PSEL = 1'b1; PWRITE = 1'b1; PENABLE = 1'b0; PADDR = a; PWDATA = d;
    @(posedge clk); #1;
    PENABLE = 1'b1;
    @(posedge clk); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [AD-1:0] a, output logic [AW-1:0] d);
    PSEL = 1'b1; PWRITE = 1'b0; PENABLE = 1'b0; PADDR = a;
    #1;
    d = PRDATA;
    PSEL = 1'b0;
  endtask

  // Reference model: the expected result of a run over the current memory contents.
  task automatic push_expected(input int len, input logic [AW-1:0] bias);
    longint acc;
    logic [AW-1:0] pw;
    logic [CH*WW-1:0] wv;
    logic signed [WW-1:0] wl;
    logic [63:0] a64;
    exp_t e;
    acc = longint'($signed(bias));
    for (int i = 0; i < len; i++) begin
      pw = pmem[i];
      wv = wmem[i];
      for (int c = 0; c < CH; c++) begin
        wl  = wv[c*WW +: WW];
        acc = acc + longint'(pw[c*PW +: PW]) * longint'(wl);
      end
    end
    a64 = acc;
    if (acc > 64'sd8388607) e.score = 24'h7FFFFF;
    else if (acc < -64'sd8388608) e.score = 24'h800000;
    else e.score = a64[AW-1:0];
    e.cat = (acc > 64'sd0);
    e.len = len;
    sb.push_back(e);
  endtask

  task automatic start_run(input int len, input logic [AW-1:0] bias);
    apb_write(AD'(1), AW'(len));
    apb_write(AD'(2), bias);
    push_expected(len, bias);
    apb_write(AD'(0), 24'd1);
    start_cyc = cyc;
  endtask

  task automatic wait_done(input string tag);
    int n;
    exp_t e;
    n = 0;
    while (!done_irq && n < 6000) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, " irq"}, 64'(done_irq), 64'd1);
    if (sb.size() == 0) begin
      chk({tag, " scoreboard empty"}, 64'd0, 64'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, " latency"}, 64'(cyc - start_cyc), 64'(e.len + 3));
      chk({tag, " score"}, 64'(score), 64'(e.score));
      chk({tag, " cat"}, 64'(cat_rec_out), 64'(e.cat));
    end
    @(posedge clk); #1;
    chk({tag, " irq pulse width"}, 64'(done_irq), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [AW-1:0] rd;
    int irq_base, rd_base, bad_base;

    rst = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0; PWDATA = '0;
    for (int i = 0; i < 4096; i++) begin
      pmem[i] = '0;
      wmem[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset score", 64'(score), 64'd0);
    chk("reset cat", 64'(cat_rec_out), 64'd0);
    chk("reset irq", 64'(done_irq), 64'd0);
    chk("reset rd_en", 64'(mem_rd_en), 64'd0);
    chk("reset rd_addr", 64'(mem_rd_addr), 64'd0);
    chk("pready", 64'(PREADY), 64'd1);
    apb_read(AD'(3), rd);
    chk("reset status", 64'(rd), 64'd0);

    // Single word, lanes {1,2,3} x {-1,2,3}: sum 12
    pmem[0] = {8'd1, 8'd2, 8'd3};
    wmem[0] = {5'h1F, 5'd2, 5'd3};
    start_run(1, -24'sd11);
    wait_done("len1 bias-11");
    chk("len1 score const", 64'(score), 64'd1);
    apb_read(AD'(3), rd);
    chk("len1 status", 64'(rd), 64'b110);
    start_run(1, -24'sd12);
    wait_done("len1 bias-12");
    chk("len1b cat const", 64'(cat_rec_out), 64'd0);
    apb_read(AD'(3), rd);
    chk("len1b status", 64'(rd), 64'b010);

    // Four words of max pixels times most-negative weights
    for (int i = 0; i < 4; i++) begin
      pmem[i] = 24'hFFFFFF;
      wmem[i] = {5'h10, 5'h10, 5'h10};
    end
    start_run(4, 24'd0);
    wait_done("len4 neg");
    chk("len4 score const", 64'(score), 64'hFF40C0);
    apb_read(AD'(3), rd);
    chk("len4 status", 64'(rd), 64'b010);

    // Reset asserted mid-run
    irq_base = irq_count;
    apb_write(AD'(1), 24'd8);
    apb_write(AD'(0), 24'd1);
    @(posedge clk); #1;
    chk("midrun rd_en", 64'(mem_rd_en), 64'd1);
    rst = 1'b1;
    #1;
    chk("rst score", 64'(score), 64'd0);
    chk("rst cat", 64'(cat_rec_out), 64'd0);
    chk("rst rd_en", 64'(mem_rd_en), 64'd0);
    chk("rst rd_addr", 64'(mem_rd_addr), 64'd0);
    chk("rst irq", 64'(done_irq), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("rst no irq", 64'(irq_count), 64'(irq_base));
    apb_read(AD'(3), rd);
    chk("rst status", 64'(rd), 64'd0);
    apb_read(AD'(1), rd);
    chk("rst len", 64'(rd), 64'd0);

    // Full-length run saturating positive
    for (int i = 0; i < 4095; i++) begin
      pmem[i] = 24'hFFFFFF;
      wmem[i] = {5'd15, 5'd15, 5'd15};
    end
    rd_base = rd_count; bad_base = addr_bad;
    start_run(4095, 24'd0);
    wait_done("len4095");
    chk("len4095 score const", 64'(score), 64'h7FFFFF);
    chk("len4095 reads", 64'(rd_count - rd_base), 64'd4095);
    chk("len4095 addr walk", 64'(addr_bad), 64'(bad_base));

    // Abort on the third RUN cycle, then ignored writes while busy
    for (int i = 0; i < 8; i++) begin
      pmem[i] = $urandom;
      wmem[i] = CH*WW'($urandom);
    end
    irq_base = irq_count;
    apb_write(AD'(1), 24'd8);
    apb_write(AD'(2), 24'd0);
    apb_write(AD'(0), 24'd1);
    @(posedge clk); #1;
    apb_write(AD'(0), 24'd2);
    chk("abort rd_en", 64'(mem_rd_en), 64'd0);
    apb_read(AD'(3), rd);
    chk("abort status", 64'(rd), 64'b100);
    chk("abort score kept", 64'(score), 64'h7FFFFF);
    repeat (10) @(posedge clk);
    #1;
    chk("abort no irq", 64'(irq_count), 64'(irq_base));
    start_run(8, 24'd0);
    apb_write(AD'(1), 24'd2);
    apb_write(AD'(0), 24'd1);
    wait_done("after abort");
    apb_read(AD'(1), rd);
    chk("busy len write ignored", 64'(rd), 64'd8);
    repeat (15) @(posedge clk);
    #1;
    chk("busy start ignored", 64'(irq_count), 64'(irq_base + 1));

    // Zero-length runs: result is the sign of BIAS
    rd_base = rd_count;
    start_run(0, -24'sd3);
    wait_done("len0 bias-3");
    start_run(0, 24'd5);
    wait_done("len0 bias5");
    chk("len0 score const", 64'(score), 64'd5);
    chk("len0 no reads", 64'(rd_count), 64'(rd_base));
    irq_base = irq_count;
    apb_write(AD'(0), 24'd3);
    repeat (10) @(posedge clk);
    #1;
    apb_read(AD'(3), rd);
    chk("start+abort status", 64'(rd), 64'b110);
    chk("start+abort no irq", 64'(irq_count), 64'(irq_base));
    chk("start+abort no reads", 64'(rd_count), 64'(rd_base));
    apb_write(AD'(0), 24'd2);
    apb_read(AD'(3), rd);
    chk("idle abort status", 64'(rd), 64'b110);
    chk("idle abort score", 64'(score), 64'd5);

    // Register map corners
    apb_read(AD'(0), rd);
    chk("ctrl reads 0", 64'(rd), 64'd0);
    apb_read(AD'(2), rd);
    chk("bias readback", 64'(rd), 64'd5);
    apb_read(AD'(4), rd);
    chk("score readback", 64'(rd), 64'd5);
    apb_write(AD'(5), 24'hABCDEF);
    apb_read(AD'(5), rd);
    chk("unmapped reads 0", 64'(rd), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
